// File: rtl/motion_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : motion_frame_scheduler
// Description : Decides when to ask the JSON translator for a motion frame,
//               captures the frame bytes the translator emits into a small
//               byte FIFO and streams them to a UART transmitter with a
//               valid/ready handshake.
//               Frames are launched on a pending emergency stop (highest
//               priority), on a changed motion command, or on heartbeat
//               expiry, which resends the last completed command.
// Revision    : 1.0 - initial release
//
// Optional feature macro: FRAME_NEWLINE_EN
//   When defined, a 0x0A byte is appended after the 27 translator bytes, so
//   every frame is 28 bytes and frame_done marks acceptance of the newline.
//
// Ports
//   clk          in   1  sole clock, rising edge
//   reset        in   1  synchronous, active-high reset
//   cmd_in       in   3  requested command (6 and 7 behave as 0, stop)
//   cmd_in_valid in   1  cmd_in qualifier
//   estop        in   1  emergency stop level
//   tr_command   out  3  command handed to the translator
//   tr_valid     out  1  one-cycle translator start pulse
//   tr_busy      in   1  translator transmitting flag
//   tr_byte      in   8  translator ASCII byte
//   tx_data      out  8  byte towards the UART
//   tx_valid     out  1  tx_data valid
//   tx_ready     in   1  UART accepts tx_data
//   sent_cmd     out  3  last command whose frame was fully transmitted
//   frame_done   out  1  one-cycle pulse after the final frame byte
// ============================================================================
module motion_frame_scheduler #(
    parameter int HEARTBEAT_CYCLES = 50_000_000,
    parameter int FIFO_DEPTH       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] cmd_in,
    input  logic       cmd_in_valid,
    input  logic       estop,
    output logic [2:0] tr_command,
    output logic       tr_valid,
    input  logic       tr_busy,
    input  logic [7:0] tr_byte,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [2:0] sent_cmd,
    output logic       frame_done
);

    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam int c_HW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

    localparam logic [c_HW-1:0] c_HB_LAST  = c_HW'(HEARTBEAT_CYCLES - 1);
    localparam logic [c_AW-1:0] c_PTR_LAST = c_AW'(FIFO_DEPTH - 1);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_LAUNCH  = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [1:0] c_ST_DRAIN   = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;

    logic            r_busy_d;
    logic            r_estop_d;
    logic            r_estop_pend;
    logic            r_cmd_pend;
    logic [2:0]      r_cmd_pend_val;
    logic [2:0]      r_tr_cmd;
    logic [2:0]      r_sent_cmd;
    logic            r_frame_done;
    logic [c_HW-1:0] r_hb;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic [2:0]      w_cmd_norm;
    logic            w_req;
    logic            w_req_changed;
    logic            w_estop_rise;
    logic            w_hb_expired;
    logic            w_trigger;
    logic            w_launch;
    logic [2:0]      w_launch_cmd;
    logic            w_busy_fall;
    logic            w_capture;
    logic            w_push_req;
    logic            w_push;
    logic [7:0]      w_wdata;
    logic            w_tx_valid;
    logic            w_pop;
    logic            w_src_done;
    logic            w_frame_end;

    // ------------------------------------------------------------------
    // Request decoding and trigger selection
    // ------------------------------------------------------------------
    assign w_cmd_norm    = (cmd_in > 3'd5) ? 3'd0 : cmd_in;
    assign w_req         = cmd_in_valid && !estop;
    // r_tr_cmd only changes at launch, so it is the last launched command.
    assign w_req_changed = w_req && (w_cmd_norm != r_tr_cmd);
    assign w_estop_rise  = estop && !r_estop_d;
    assign w_hb_expired  = (r_hb == c_HB_LAST);
    assign w_trigger     = r_estop_pend || r_cmd_pend || w_hb_expired;
    assign w_launch      = (r_state == c_ST_IDLE) && w_trigger && !tr_busy;
    assign w_launch_cmd  = r_estop_pend ? 3'd0 :
                           r_cmd_pend   ? r_cmd_pend_val : r_sent_cmd;

    // ------------------------------------------------------------------
    // Byte capture and drain
    // ------------------------------------------------------------------
    // The first busy cycle carries no byte; data is valid from the second.
    assign w_busy_fall = r_busy_d && !tr_busy;
    assign w_capture   = (r_state == c_ST_CAPTURE) && tr_busy && r_busy_d;
`ifdef FRAME_NEWLINE_EN
    assign w_push_req  = w_capture || ((r_state == c_ST_CAPTURE) && w_busy_fall);
    assign w_wdata     = w_capture ? tr_byte : 8'h0A;
`else
    assign w_push_req  = w_capture;
    assign w_wdata     = tr_byte;
`endif
    assign w_push      = w_push_req && (r_count != c_CNT_FULL);

    assign w_tx_valid  = ((r_state == c_ST_CAPTURE) || (r_state == c_ST_DRAIN)) &&
                         (r_count != '0);
    assign w_pop       = w_tx_valid && tx_ready;

    // No more bytes can arrive once the translator has dropped busy, so the
    // pop that empties the FIFO then is the last byte of the frame. With a
    // fast UART this can already happen in the busy-fall cycle.
    assign w_src_done  = (r_state == c_ST_DRAIN) ||
                         ((r_state == c_ST_CAPTURE) && w_busy_fall);
    assign w_frame_end = w_src_done && w_pop && !w_push && (r_count == c_CW'(1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_launch) w_state_next = c_ST_LAUNCH;
            c_ST_LAUNCH:  w_state_next = c_ST_CAPTURE;
            // Skip DRAIN when the final byte already left in this cycle so
            // the heartbeat starts counting right after frame_done.
            c_ST_CAPTURE: if (w_busy_fall) w_state_next = w_frame_end ? c_ST_IDLE : c_ST_DRAIN;
            c_ST_DRAIN:   if (w_frame_end || (r_count == '0)) w_state_next = c_ST_IDLE;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pending request, launch and completion registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_d       <= 1'b0;
            r_estop_d      <= 1'b0;
            r_estop_pend   <= 1'b1;     // a STOP frame goes out first
            r_cmd_pend     <= 1'b0;
            r_cmd_pend_val <= 3'd0;
            r_tr_cmd       <= 3'd0;
            r_sent_cmd     <= 3'd0;
            r_frame_done   <= 1'b0;
            r_hb           <= '0;
        end else begin
            r_busy_d     <= tr_busy;
            r_estop_d    <= estop;
            r_frame_done <= w_frame_end;

            if (w_launch) begin
                r_tr_cmd <= w_launch_cmd;
                if (r_estop_pend) begin
                    r_estop_pend <= 1'b0;
                end else begin
                    r_cmd_pend <= 1'b0;
                end
            end

            // Later assignments win: new requests override the launch clear.
            if (w_estop_rise) begin
                r_estop_pend <= 1'b1;
                r_cmd_pend   <= 1'b0;
            end else if (w_req) begin
                if (w_req_changed) begin
                    r_cmd_pend     <= 1'b1;
                    r_cmd_pend_val <= w_cmd_norm;
                end else begin
                    // Latest request matches what is already on the wire.
                    r_cmd_pend <= 1'b0;
                end
            end

            if (w_frame_end) begin
                r_sent_cmd <= r_tr_cmd;
            end

            // Saturates at the last value so an expiry blocked by tr_busy
            // stays armed until the launch happens.
            if (w_frame_end) begin
                r_hb <= '0;
            end else if ((r_state == c_ST_IDLE) && !w_hb_expired) begin
                r_hb <= r_hb + c_HW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tr_valid   = (r_state == c_ST_LAUNCH);
    assign tr_command = r_tr_cmd;
    assign tx_valid   = w_tx_valid;
    assign tx_data    = w_tx_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign sent_cmd   = r_sent_cmd;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
